// File: rtl/fifo_rd_packer_if.sv
// Read-side packer bus: FIFO read port, flush request and the packed output stream.
// master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int LANES = 4,
  parameter int CSIZE = 16
);
  logic [DSIZE-1:0]       rdata;
  logic                   rempty;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*LANES-1:0] out_data;
  logic [LANES-1:0]       out_keep;
  logic                   out_valid;
  logic                   out_ready;
  logic [CSIZE-1:0]       word_cnt;

  modport master (
    input  rdata, rempty, flush, out_ready,
    output rinc, out_data, out_keep, out_valid, word_cnt
  );

  modport slave (
    output rdata, rempty, flush, out_ready,
    input  rinc, out_data, out_keep, out_valid, word_cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs entries little-endian into
// LANES-wide words on a valid/ready stream; flush emits a partial word with a keep mask.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int LANES = 4,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  fifo_rd_packer_if.master bus
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(LANES - 1);
  localparam logic [CSIZE-1:0] WC_ONE   = CSIZE'(1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [DSIZE*LANES-1:0] r_asm;
  logic [DSIZE*LANES-1:0] w_asm_nxt;
  logic [DSIZE*LANES-1:0] r_out_data;
  logic [LANES-1:0]       r_out_keep;
  logic [LANES-1:0]       w_keep_part;
  logic [CSIZE-1:0]       r_word_cnt;
  logic                   w_rinc;
  logic                   w_last;
  logic                   w_flush_go;

  assign w_last     = (r_cnt == CNT_LAST);
  assign w_flush_go = (r_state == S_FILL) && bus.flush && (r_cnt != {CW{1'b0}});

  // state register
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if ((w_rinc && w_last) || w_flush_go) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // pop strobe is purely combinational so the FIFO sees it in the same cycle
  always_comb begin
    w_rinc = 1'b0;
    if (rrst_n && (r_state == S_FILL) && !bus.rempty && !bus.flush) begin
      w_rinc = 1'b1;
    end else begin
      w_rinc = 1'b0;
    end
  end

  // assembly word with the current entry dropped into lane r_cnt; flush keep mask
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[r_cnt*DSIZE +: DSIZE] = bus.rdata;
    w_keep_part = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_keep_part[i] = (i < int'(r_cnt));
    end
  end

  // datapath: lane fill, word capture and delivered-word counter
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_asm      <= {(DSIZE*LANES){1'b0}};
      r_out_data <= {(DSIZE*LANES){1'b0}};
      r_out_keep <= {LANES{1'b0}};
      r_word_cnt <= {CSIZE{1'b0}};
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_rinc) begin
            if (w_last) begin
              r_out_data <= w_asm_nxt;
              r_out_keep <= {LANES{1'b1}};
              r_cnt      <= {CW{1'b0}};
              r_asm      <= {(DSIZE*LANES){1'b0}};
            end else begin
              r_asm <= w_asm_nxt;
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (w_flush_go) begin
            // unused lanes of r_asm are already zero
            r_out_data <= r_asm;
            r_out_keep <= w_keep_part;
            r_cnt      <= {CW{1'b0}};
            r_asm      <= {(DSIZE*LANES){1'b0}};
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_word_cnt <= r_word_cnt + WC_ONE;
          end else begin
            r_word_cnt <= r_word_cnt;
          end
        end
        default: r_cnt <= {CW{1'b0}};
      endcase
    end
  end

  assign bus.rinc      = w_rinc;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.out_keep  = r_out_keep;
  assign bus.word_cnt  = r_word_cnt;
endmodule
